instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch/prefetch unit that produces the 16-bit instruction word consumed by the core's instruction decoder. It owns the fetch PC and issues single-outstanding reads to instruction RAM. Fetched words are buffered in a small FIFO and handed to the decode stage with a valid/ready handshake. Taken-branch redirects from execute flush the buffer and restart fetching at the new PC.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
RESET_PC, 16'h0000, fetch PC after reset.
NOP_WORD, 16'h0000, value driven on instr when instr_valid=0; decodes as a shift of R0 by 0.

Ports:
clk  input  1  core clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
mem_addr  output  16  instruction RAM word address
mem_read  output  1  read request; held with mem_addr stable until mem_ready
mem_data  input  16  read data; valid in the cycle mem_ready=1
mem_ready  input  1  read completes this cycle
instr  output  16  head-of-FIFO instruction word for the decoder
instr_pc  output  16  address instr was fetched from
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  decode/execute consumes head this cycle
redirect  input  1  taken branch: flush and refetch
redirect_pc  input  16  new fetch target, sampled when redirect=1

Behaviour:
- Reset (reset_n=0 at a clock edge): fetch_pc=RESET_PC, FIFO empty, mem_read=0, mem_addr=RESET_PC, instr_valid=0, instr=NOP_WORD, instr_pc=0, state=IDLE. Reset mid-request abandons it; a late mem_ready after reset is ignored.
- Handshake out: a pop occurs when instr_valid & instr_ready. instr and instr_pc are registered FIFO head outputs; no combinational path from instr_ready to instr.
- Credit rule: a new request is issued only if occupancy + outstanding < DEPTH, so returning data always has space. Pop and push in the same cycle are both honoured; occupancy is unchanged.
- FSM states:
  - IDLE: if redirect, load fetch_pc=redirect_pc. Else, if credit is available, go to REQ with mem_read=1 and mem_addr=fetch_pc.
  - REQ: hold mem_addr and mem_read. On mem_ready, push {fetch_pc, mem_data} and set fetch_pc=fetch_pc+1, wrapping 16'hFFFF->16'h0000. Then issue the next request back-to-back (mem_read stays 1) if credit allows; otherwise go to IDLE.
  - DISCARD: a redirect arrived while a request was pending without mem_ready. Keep mem_read and mem_addr stable until mem_ready, drop the returned data, then go to REQ at fetch_pc (already loaded with redirect_pc).
- Redirect (priority over everything except reset):
  - FIFO cleared that cycle, so instr_valid=0 next cycle; any same-cycle pop is void.
  - fetch_pc=redirect_pc.
  - Same-cycle mem_ready: data discarded, next request at redirect_pc the following cycle.
  - Pending without mem_ready: go to DISCARD.
- Redirect in DISCARD: update fetch_pc again; remain in DISCARD.
- Latency: from redirect to first instr_valid is 2 cycles with zero-wait RAM (request cycle, then push). Zero-wait RAM sustains 1 instruction/cycle with instr_ready held high.
- Full: with occupancy=DEPTH, mem_read=0 until a pop. Empty: instr_valid=0, instr=NOP_WORD.
- The address counter is 16-bit modulo; no overflow flag.

Test Plan:
- Reset, then zero-wait RAM returning mem_data=addr^16'hA5A5, instr_ready=1 -> instr_valid at cycle 2; instr_pc = 0,1,2,… consecutively; instr = 16'hA5A5, 16'hA5A4, …; no gaps.
- instr_ready=0 with DEPTH=4 -> exactly 4 reads (addr 0..3), then mem_read=0 and held. Raise instr_ready for 1 cycle -> one pop, exactly one new read at addr 4.
- RAM with 3 wait states, redirect to 16'h0100 on the 2nd wait cycle -> mem_addr stays stable until mem_ready, returned word never appears on instr, next mem_addr=16'h0100, first valid instr_pc=16'h0100.
- Redirect coincident with mem_ready and a pop -> FIFO empty next cycle, data dropped, mem_addr=redirect_pc the following cycle.
- redirect_pc=16'hFFFE, zero-wait -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Assert reset_n=0 during REQ with FIFO half full -> next cycle all outputs at reset values; a later stray mem_ready is ignored; fetching resumes at RESET_PC after reset_n=1.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch/prefetch unit. Owns the fetch PC, issues
//             single-outstanding reads to instruction RAM, buffers returned
//             words in a small FIFO and presents the head to decode with a
//             valid/ready handshake. Taken-branch redirects flush the buffer
//             and restart fetching at the new PC.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int                c_AW    = $clog2(DEPTH);
  localparam int                c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0]   c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_AW-1:0]   c_PTR_1 = c_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_fetch_pc;
  logic [15:0]       w_fetch_pc_next;
  logic [15:0]       r_mem_addr;
  logic [15:0]       w_mem_addr_next;

  logic [15:0]       r_buf_data [DEPTH];
  logic [15:0]       r_buf_pc   [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW-1:0]   w_rd_ptr_next;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   w_count_after_pop;
  logic [c_CW-1:0]   w_count_next;

  logic              r_valid;
  logic [15:0]       r_instr;
  logic [15:0]       r_instr_pc;
  logic [15:0]       w_head_data;
  logic [15:0]       w_head_pc;

  logic              w_push;
  logic              w_pop;
  logic              w_credit;

  assign mem_addr    = r_mem_addr;
  assign mem_read    = (r_state != S_IDLE);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

  // Push/pop qualification and next occupancy; a redirect voids both and empties the buffer.
  always_comb begin
    w_pop             = r_valid & instr_ready & ~redirect;
    w_push            = (r_state == S_REQ) & mem_ready & ~redirect;
    w_count_after_pop = r_count - c_CW'(w_pop);
    w_count_next      = redirect ? '0 : (w_count_after_pop + c_CW'(w_push));
    // Credit counts occupancy after this cycle; the next request is only
    // issued when its data is guaranteed a free slot.
    w_credit          = (w_count_next < c_DEPTH);
  end

  // Next-state and next fetch/request address.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_mem_addr_next = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          // Buffer is flushed this cycle, so credit is always available.
          w_fetch_pc_next = redirect_pc;
          w_mem_addr_next = redirect_pc;
          w_state_next    = S_REQ;
        end else if (w_credit) begin
          w_mem_addr_next = r_fetch_pc;
          w_state_next    = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          if (mem_ready) begin
            w_mem_addr_next = redirect_pc;
            w_state_next    = S_REQ;
          end else begin
            // Request still in flight: keep it stable and drop its data.
            w_state_next    = S_DISCARD;
          end
        end else if (mem_ready) begin
          w_fetch_pc_next = r_fetch_pc + 16'd1;
          w_mem_addr_next = r_fetch_pc + 16'd1;
          w_state_next    = w_credit ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
        end
        if (mem_ready) begin
          w_mem_addr_next = redirect ? redirect_pc : r_fetch_pc;
          w_state_next    = S_REQ;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and request address registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  // Value the head output registers take next cycle (bypass when pushing into an empty buffer).
  always_comb begin
    w_rd_ptr_next = r_rd_ptr + c_AW'(w_pop);
    w_head_data   = NOP_WORD;
    w_head_pc     = '0;
    if (w_count_next != '0) begin
      if (w_count_after_pop == '0) begin
        w_head_data = mem_data;
        w_head_pc   = r_fetch_pc;
      end else begin
        w_head_data = r_buf_data[w_rd_ptr_next];
        w_head_pc   = r_buf_pc[w_rd_ptr_next];
      end
    end
  end

  // Prefetch buffer storage; written on every accepted return.
  always_ff @(posedge clk) begin
    if (reset_n && w_push) begin
      r_buf_data[r_wr_ptr] <= mem_data;
      r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  // Buffer pointers, occupancy and registered head outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_instr    <= NOP_WORD;
      r_instr_pc <= '0;
    end else begin
      if (redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_1;
        end
      end
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      r_instr    <= w_head_data;
      r_instr_pc <= w_head_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch: RAM model with configurable
//             wait states, queue scoreboard of expected instructions, a
//             per-cycle vector table for back-pressure, and hand sequences
//             for redirect and reset corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [15:0] c_NOP  = 16'h0000;
  localparam logic [15:0] c_RPC  = 16'h0000;
  localparam logic [15:0] c_XOR  = 16'hA5A5;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  instr_fetch #(
    .DEPTH    (4),
    .RESET_PC (c_RPC),
    .NOP_WORD (c_NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  ent_t        q[$];
  vec_t        tbl[9];
  logic [15:0] exp_fetch;
  logic [15:0] disc_addr;
  logic        drop_pending;
  int          wait_cnt;
  int          g_waits;
  int          n_checks;
  int          n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset(input int waits);
    q.delete();
    exp_fetch    = c_RPC;
    disc_addr    = 16'h0;
    drop_pending = 1'b0;
    wait_cnt     = 0;
    g_waits      = waits;
  endtask

  // Called at a falling edge: check outputs against the model, drive the
  // next cycle's inputs, update the model, advance to the next falling edge.
  task automatic tick(input logic rdy, input logic redir, input logic [15:0] rpc);
    logic        s_rd;
    logic        s_valid;
    logic        rdy_mem;
    logic [15:0] s_addr;
    s_rd    = mem_read;
    s_addr  = mem_addr;
    s_valid = instr_valid;
    chk("valid_vs_model", {31'b0, s_valid}, {31'b0, q.size() != 0});
    if (s_valid && q.size() != 0) begin
      chk("head_pc", {16'b0, instr_pc}, {16'b0, q[0].pc});
      chk("head_instr", {16'b0, instr}, {16'b0, q[0].data});
    end
    if (!s_valid) chk("nop_when_empty", {16'b0, instr}, {16'b0, c_NOP});
    if (s_rd) chk("req_addr", {16'b0, s_addr}, {16'b0, drop_pending ? disc_addr : exp_fetch});
    rdy_mem = s_rd && (wait_cnt >= g_waits);
    if (s_rd) wait_cnt = rdy_mem ? 0 : wait_cnt + 1;
    mem_ready   = rdy_mem;
    mem_data    = rdy_mem ? (s_addr ^ c_XOR) : 16'hDEAD;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (redir) begin
      if (s_rd && !rdy_mem) begin
        if (!drop_pending) disc_addr = exp_fetch;
        drop_pending = 1'b1;
      end else begin
        drop_pending = 1'b0;
      end
      q.delete();
      exp_fetch = rpc;
    end else begin
      if (s_valid && rdy && q.size() != 0) void'(q.pop_front());
      if (rdy_mem) begin
        if (drop_pending) drop_pending = 1'b0;
        else begin
          q.push_back('{pc: exp_fetch, data: exp_fetch ^ c_XOR});
          exp_fetch = exp_fetch + 16'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  // Leaves the bench at the first falling edge after reset release.
  task automatic do_reset(input int waits);
    @(negedge clk);
    reset_n     = 1'b0;
    mem_ready   = 1'b0;
    mem_data    = 16'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    @(negedge clk);
    @(negedge clk);
    model_reset(waits);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input logic [15:0] exp_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick(1'b1, 1'b0, 16'h0);
      n++;
    end
    chk({name, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({name, "_pc"}, {16'b0, instr_pc}, {16'b0, exp_pc});
    chk({name, "_instr"}, {16'b0, instr}, {16'b0, exp_pc ^ c_XOR});
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] seq [4];
    n_checks    = 0;
    n_pass      = 0;
    reset_n     = 1'b0;
    mem_ready   = 1'b0;
    mem_data    = 16'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    model_reset(0);

    //            rdy   rd    addr     valid pc
    tbl[0] = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h0};
    tbl[1] = '{1'b0, 1'b1, 16'h1, 1'b1, 16'h0};
    tbl[2] = '{1'b0, 1'b1, 16'h2, 1'b1, 16'h0};
    tbl[3] = '{1'b0, 1'b1, 16'h3, 1'b1, 16'h0};
    tbl[4] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0};
    tbl[5] = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0};
    tbl[6] = '{1'b0, 1'b1, 16'h4, 1'b1, 16'h1};
    tbl[7] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h1};
    tbl[8] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h1};

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_addr", {16'b0, mem_addr}, {16'b0, c_RPC});
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", {16'b0, instr}, {16'b0, c_NOP});
    chk("rst_instr_pc", {16'b0, instr_pc}, 32'd0);

    // Back-pressure: fill to DEPTH, stall, single pop frees one credit.
    do_reset(0);
    for (int i = 0; i < 9; i++) begin
      chk("tbl_mem_read", {31'b0, mem_read}, {31'b0, tbl[i].exp_rd});
      if (tbl[i].exp_rd) chk("tbl_mem_addr", {16'b0, mem_addr}, {16'b0, tbl[i].exp_addr});
      chk("tbl_valid", {31'b0, instr_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk("tbl_pc", {16'b0, instr_pc}, {16'b0, tbl[i].exp_pc});
      tick(tbl[i].rdy, 1'b0, 16'h0);
    end

    // Sustained zero-wait streaming: valid from cycle 2, no gaps.
    do_reset(0);
    chk("lat_cycle1_valid", {31'b0, instr_valid}, 32'd0);
    tick(1'b1, 1'b0, 16'h0);
    for (int k = 2; k <= 12; k++) begin
      chk("stream_valid", {31'b0, instr_valid}, 32'd1);
      chk("stream_pc", {16'b0, instr_pc}, k - 2);
      chk("stream_instr", {16'b0, instr}, {16'b0, 16'(k - 2) ^ c_XOR});
      tick(1'b1, 1'b0, 16'h0);
    end

    // Redirect on the 2nd wait cycle of a 3-wait-state read.
    do_reset(3);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h0100);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    chk("disc_next_read", {31'b0, mem_read}, 32'd1);
    chk("disc_next_addr", {16'b0, mem_addr}, 32'h0100);
    wait_valid("disc_first", 16'h0100);

    // Redirect coincident with mem_ready and a pop.
    do_reset(0);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    chk("coinc_pre_valid", {31'b0, instr_valid}, 32'd1);
    tick(1'b1, 1'b1, 16'h0200);
    chk("coinc_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("coinc_read", {31'b0, mem_read}, 32'd1);
    chk("coinc_addr", {16'b0, mem_addr}, 32'h0200);
    tick(1'b1, 1'b0, 16'h0);
    chk("coinc_first_valid", {31'b0, instr_valid}, 32'd1);
    chk("coinc_first_pc", {16'b0, instr_pc}, 32'h0200);

    // PC wrap at 16'hFFFF.
    tick(1'b1, 1'b1, 16'hFFFE);
    tick(1'b1, 1'b0, 16'h0);
    seq[0] = 16'hFFFE;
    seq[1] = 16'hFFFF;
    seq[2] = 16'h0000;
    seq[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_valid", {31'b0, instr_valid}, 32'd1);
      chk("wrap_pc", {16'b0, instr_pc}, {16'b0, seq[i]});
      tick(1'b1, 1'b0, 16'h0);
    end

    // Reset mid-request with the buffer half full, stray mem_ready ignored.
    do_reset(0);
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 16'h0);
    chk("mid_pre_read", {31'b0, mem_read}, 32'd1);
    chk("mid_pre_addr", {16'b0, mem_addr}, 32'h2);
    reset_n     = 1'b0;
    mem_ready   = 1'b1;
    mem_data    = 16'h2 ^ c_XOR;
    instr_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_read", {31'b0, mem_read}, 32'd0);
    chk("mid_rst_addr", {16'b0, mem_addr}, {16'b0, c_RPC});
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("mid_rst_instr", {16'b0, instr}, {16'b0, c_NOP});
    chk("mid_rst_pc", {16'b0, instr_pc}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("stray_valid", {31'b0, instr_valid}, 32'd0);
    chk("resume_read", {31'b0, mem_read}, 32'd1);
    chk("resume_addr", {16'b0, mem_addr}, {16'b0, c_RPC});
    model_reset(0);
    wait_valid("resume_first", c_RPC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
